// File: rtl/framebuffer_writer_pkg.sv
// Shared types and constants for the framebuffer writer: screen geometry,
// framebuffer write record and the buffer-swap state encoding.
package framebuffer_writer_pkg;

  localparam int FB_SCREEN_WIDTH  = 320;
  localparam int FB_SCREEN_HEIGHT = 180;
  localparam int FB_ADDR_WIDTH    = 17;
  localparam int FB_PIXELS        = FB_SCREEN_WIDTH * FB_SCREEN_HEIGHT;

  typedef logic [8:0] ScreenX;
  typedef logic [7:0] ScreenY;

  typedef struct packed {
    logic [FB_ADDR_WIDTH-1:0] addr;
    logic [15:0]              data;
  } FbWrite;

  typedef enum logic [2:0] {
    RENDER      = 3'd0,
    DRAIN       = 3'd1,
    WAIT_VBLANK = 3'd2,
    SWAP        = 3'd3,
    CLEAR       = 3'd4
  } fbwr_state;

endpackage

// File: rtl/framebuffer_writer_fifo.sv
// pixel_fifo: small synchronous FIFO of framebuffer writes with full/empty
// flags; a pop frees its slot for a push in the same cycle.
module pixel_fifo
  import framebuffer_writer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_i,
  input  FbWrite push_data_i,
  input  logic   pop_i,
  output FbWrite head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int PW = $clog2(DEPTH);

  FbWrite          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [PW:0]     count_q;
  logic            do_pop;
  logic            do_push;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (do_push && (wr_ptr_q == PW'(gi))) begin
          mem_q[gi] <= push_data_i;
        end
      end
    end
  endgenerate

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/framebuffer_writer.sv
// Writes the renderer's pixel stream into a double-buffered framebuffer and
// swaps buffers on vblank. Define FRAMEBUFFER_CLEAR_ON_SWAP_EN to zero the new back buffer after each swap.
module framebuffer_writer
  import framebuffer_writer_pkg::*;
#(
  parameter int SCREEN_WIDTH  = FB_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = FB_SCREEN_HEIGHT,
  parameter int FIFO_DEPTH    = 8,
  parameter int ADDR_WIDTH    = FB_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pixel_valid_in,
  input  ScreenX                pixel_x_in,
  input  ScreenY                pixel_y_in,
  input  logic [15:0]           pixel_value_in,
  input  logic                  render_busy,
  input  logic                  vblank,
  input  logic                  fb_ready,
  output logic                  fb_we,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  output logic [15:0]           fb_data,
  output logic                  front_buf,
  output logic                  frame_swapped,
  output logic                  overflow
);

  localparam int PIXELS = SCREEN_WIDTH * SCREEN_HEIGHT;

  fbwr_state state_q, state_d;
  logic      busy_prev_q;
  logic      front_buf_q;
  logic      frame_swapped_q;
  logic      overflow_q;
  logic      stage_valid_q;
  FbWrite    stage_q;

  logic                  busy_fall;
  logic                  busy_rise;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] buf_base;
  logic [ADDR_WIDTH-1:0] pix_addr;
  FbWrite                fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;

  assign busy_fall = busy_prev_q && !render_busy;
  assign busy_rise = !busy_prev_q && render_busy;

  // The back buffer is always the one the display is not reading.
  assign buf_base = front_buf_q ? '0 : ADDR_WIDTH'(PIXELS);
  assign in_range = pixel_valid_in
                 && (int'(pixel_x_in) < SCREEN_WIDTH)
                 && (int'(pixel_y_in) < SCREEN_HEIGHT);
  assign pix_addr = ADDR_WIDTH'(pixel_y_in) * ADDR_WIDTH'(SCREEN_WIDTH)
                  + ADDR_WIDTH'(pixel_x_in) + buf_base;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid_q <= 1'b0;
      stage_q       <= '0;
    end else begin
      stage_valid_q <= in_range;
      if (in_range) begin
        stage_q.addr <= FB_ADDR_WIDTH'(pix_addr);
        stage_q.data <= pixel_value_in;
      end
    end
  end

  pixel_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (stage_valid_q),
    .push_data_i(stage_q),
    .pop_i      (fb_ready),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign pop = fb_ready && !fifo_empty;

`ifdef FRAMEBUFFER_CLEAR_ON_SWAP_EN
  logic [ADDR_WIDTH-1:0] clear_cnt_q;
  logic                  clear_pending_q;
  logic                  clear_we;
  logic                  clear_last;

  // Queued pixels always pre-empt the background clear.
  assign clear_we   = (state_q == CLEAR) && fb_ready && fifo_empty;
  assign clear_last = (clear_cnt_q == ADDR_WIDTH'(PIXELS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      clear_cnt_q     <= '0;
      clear_pending_q <= 1'b0;
    end else begin
      if (state_q == SWAP) clear_cnt_q <= '0;
      else if (clear_we)   clear_cnt_q <= clear_cnt_q + 1'b1;
      clear_pending_q <= (state_q == CLEAR) && (clear_pending_q || busy_fall);
    end
  end
`endif

  always_comb begin
    fb_we   = 1'b0;
    fb_addr = '0;
    fb_data = '0;
    if (pop) begin
      fb_we   = 1'b1;
      fb_addr = ADDR_WIDTH'(fifo_head.addr);
      fb_data = fifo_head.data;
    end
`ifdef FRAMEBUFFER_CLEAR_ON_SWAP_EN
    else if (clear_we) begin
      fb_we   = 1'b1;
      fb_addr = clear_cnt_q + buf_base;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RENDER: begin
        if (busy_fall) state_d = DRAIN;
      end
      DRAIN: begin
        if (busy_rise)                         state_d = RENDER;
        else if (fifo_empty && !stage_valid_q) state_d = WAIT_VBLANK;
      end
      WAIT_VBLANK: begin
        if (busy_rise)   state_d = RENDER;
        else if (vblank) state_d = SWAP;
      end
      SWAP: begin
`ifdef FRAMEBUFFER_CLEAR_ON_SWAP_EN
        state_d = CLEAR;
`else
        state_d = RENDER;
`endif
      end
`ifdef FRAMEBUFFER_CLEAR_ON_SWAP_EN
      CLEAR: begin
        if (clear_we && clear_last) begin
          state_d = (clear_pending_q || busy_fall) ? DRAIN : RENDER;
        end
      end
`endif
      default: state_d = RENDER;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= RENDER;
      busy_prev_q     <= 1'b0;
      front_buf_q     <= 1'b0;
      frame_swapped_q <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      busy_prev_q     <= render_busy;
      frame_swapped_q <= (state_q == SWAP);
      if (state_q == SWAP) front_buf_q <= ~front_buf_q;
      if (stage_valid_q && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  assign front_buf     = front_buf_q;
  assign frame_swapped = frame_swapped_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed bench for framebuffer_writer: vector table for address mapping,
// plus hand-written sequences for overflow, reset, swap and abort.
module tb_framebuffer_writer;
  import framebuffer_writer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        pixel_valid_in;
  ScreenX      pixel_x_in;
  ScreenY      pixel_y_in;
  logic [15:0] pixel_value_in;
  logic        render_busy;
  logic        vblank;
  logic        fb_ready;
  logic        fb_we;
  logic [16:0] fb_addr;
  logic [15:0] fb_data;
  logic        front_buf;
  logic        frame_swapped;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;

  framebuffer_writer dut (
    .clk           (clk),
    .rst           (rst),
    .pixel_valid_in(pixel_valid_in),
    .pixel_x_in    (pixel_x_in),
    .pixel_y_in    (pixel_y_in),
    .pixel_value_in(pixel_value_in),
    .render_busy   (render_busy),
    .vblank        (vblank),
    .fb_ready      (fb_ready),
    .fb_we         (fb_we),
    .fb_addr       (fb_addr),
    .fb_data       (fb_data),
    .front_buf     (front_buf),
    .frame_swapped (frame_swapped),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          x;
    int          y;
    logic [15:0] value;
    logic        exp_we;
    logic [16:0] exp_addr;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic strobe(input int x, input int y, input logic [15:0] v);
    pixel_x_in     = ScreenX'(x);
    pixel_y_in     = ScreenY'(y);
    pixel_value_in = v;
    pixel_valid_in = 1'b1;
    tick();
    pixel_valid_in = 1'b0;
  endtask

  initial begin
    bit seen;
    int zero_cnt;
    bit beef_seen;

    vecs[0] = '{3,   2,   16'hF800, 1'b1, 17'd58243,  16'hF800};
    vecs[1] = '{0,   0,   16'h0001, 1'b1, 17'd57600,  16'h0001};
    vecs[2] = '{319, 179, 16'hFFFF, 1'b1, 17'd115199, 16'hFFFF};
    vecs[3] = '{319, 0,   16'h07E0, 1'b1, 17'd57919,  16'h07E0};
    vecs[4] = '{0,   179, 16'h001F, 1'b1, 17'd114880, 16'h001F};
    vecs[5] = '{320, 0,   16'h1234, 1'b0, 17'd0,      16'h0000};
    vecs[6] = '{0,   180, 16'h5678, 1'b0, 17'd0,      16'h0000};
    vecs[7] = '{100, 50,  16'hABCD, 1'b1, 17'd73700,  16'hABCD};

    rst = 1'b1; pixel_valid_in = 1'b0; pixel_x_in = '0; pixel_y_in = '0;
    pixel_value_in = '0; render_busy = 1'b0; vblank = 1'b0; fb_ready = 1'b1;
    tick(); tick(); tick();
    chk("reset fb_we", 32'(fb_we), 0);
    chk("reset fb_addr", 32'(fb_addr), 0);
    chk("reset fb_data", 32'(fb_data), 0);
    chk("reset front_buf", 32'(front_buf), 0);
    chk("reset frame_swapped", 32'(frame_swapped), 0);
    chk("reset overflow", 32'(overflow), 0);
    rst = 1'b0;
    tick();

    // Address mapping into back buffer 1, including out-of-range discards.
    for (int i = 0; i < 8; i++) begin
      strobe(vecs[i].x, vecs[i].y, vecs[i].value);
      tick();
      chk($sformatf("vec%0d fb_we", i), 32'(fb_we), 32'(vecs[i].exp_we));
      chk($sformatf("vec%0d fb_addr", i), 32'(fb_addr), 32'(vecs[i].exp_addr));
      chk($sformatf("vec%0d fb_data", i), 32'(fb_data), 32'(vecs[i].exp_data));
      tick();
    end
    chk("oor overflow stays 0", 32'(overflow), 0);

    // Nine pushes into an 8-deep FIFO with the write port stalled.
    fb_ready = 1'b0;
    for (int i = 0; i < 9; i++) strobe(i, 10, 16'h0100 + 16'(i));
    tick(); tick();
    chk("ovf overflow", 32'(overflow), 1);
    chk("ovf stalled fb_we", 32'(fb_we), 0);
    fb_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("drain%0d fb_we", i), 32'(fb_we), 1);
      chk($sformatf("drain%0d fb_addr", i), 32'(fb_addr), 32'(60800 + i));
      chk($sformatf("drain%0d fb_data", i), 32'(fb_data), 32'(16'h0100 + 16'(i)));
      tick();
    end
    #1;
    chk("drain done fb_we", 32'(fb_we), 0);
    chk("ovf sticky", 32'(overflow), 1);

    // Reset with queued pixels drops them and clears overflow.
    fb_ready = 1'b0;
    strobe(5, 5, 16'h1111); strobe(6, 5, 16'h2222);
    rst = 1'b1;
    tick();
    fb_ready = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst fb_we", 32'(fb_we), 0);
    chk("rst overflow", 32'(overflow), 0);
    tick();
    chk("rst fifo dropped", 32'(fb_we), 0);
    tick();

    // Frame completes then restarts before vblank: swap aborted.
    render_busy = 1'b1; tick();
    render_busy = 1'b0; tick();
    tick();
    render_busy = 1'b1; tick();
    vblank = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("abort%0d frame_swapped", i), 32'(frame_swapped), 0);
    end
    vblank = 1'b0;
    chk("abort front_buf", 32'(front_buf), 0);

    // Frame completes with three pixels queued; swap waits for drain and vblank.
    fb_ready = 1'b0;
    strobe(1, 1, 16'h0A01); strobe(2, 1, 16'h0A02); strobe(3, 1, 16'h0A03);
    tick();
    render_busy = 1'b0; tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("hold%0d frame_swapped", i), 32'(frame_swapped), 0);
    end
    fb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("q%0d fb_addr", i), 32'(fb_addr), 32'(57921 + i));
      chk($sformatf("q%0d fb_data", i), 32'(fb_data), 32'(16'h0A01 + 16'(i)));
      tick();
    end
    tick(); tick(); tick();
    chk("novb frame_swapped", 32'(frame_swapped), 0);
    chk("novb front_buf", 32'(front_buf), 0);
    vblank = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (frame_swapped) seen = 1'b1;
    end
    chk("swap pulse seen", 32'(seen), 1);
    chk("swap front_buf", 32'(front_buf), 1);
    vblank = 1'b0;

`ifdef FRAMEBUFFER_CLEAR_ON_SWAP_EN
    zero_cnt = 0;
    beef_seen = 1'b0;
    for (int i = 0; i < 60000; i++) begin
      if (i == 5) begin
        pixel_x_in = '0; pixel_y_in = '0; pixel_value_in = 16'hBEEF;
        pixel_valid_in = 1'b1;
      end else begin
        pixel_valid_in = 1'b0;
      end
      if (i > 10 && !fb_we) break;
      if (fb_we && fb_data == 16'h0000 && fb_addr < 17'd57600) zero_cnt++;
      if (fb_we && fb_data == 16'hBEEF && fb_addr == 17'd0) beef_seen = 1'b1;
      tick();
    end
    chk("clear zero writes", 32'(zero_cnt), 57600);
    chk("clear pixel landed", 32'(beef_seen), 1);
    tick();
    chk("clear finished fb_we", 32'(fb_we), 0);
`else
    tick();
    chk("pulse width", 32'(frame_swapped), 0);
    strobe(0, 0, 16'hBEEF);
    tick();
    chk("new back fb_we", 32'(fb_we), 1);
    chk("new back fb_addr", 32'(fb_addr), 0);
    chk("new back fb_data", 32'(fb_data), 32'(16'hBEEF));
    tick();
`endif
    chk("final front_buf", 32'(front_buf), 1);
    chk("final overflow", 32'(overflow), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/framebuffer_writer.md
Name: framebuffer_writer

Overview:
- Downstream of the raytracing controller: consumes its per-pixel stream (valid strobe, pixel_x, pixel_y, 16-bit colour) and writes each pixel into a double-buffered framebuffer BRAM.
- Buffers pixels in a small FIFO so the display read port can stall the write port without loss.
- Swaps front/back buffers at the first vblank after a frame completes, so the display never shows a partial frame.

Parameters:
- SCREEN_WIDTH, 320, pixels per row.
- SCREEN_HEIGHT, 180, rows per frame.
- FIFO_DEPTH, 8, pixel FIFO entries; must be a power of two.
- ADDR_WIDTH, 17, framebuffer address width; must satisfy 2^ADDR_WIDTH >= 2*SCREEN_WIDTH*SCREEN_HEIGHT.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- pixel_valid_in  in  1  one-cycle strobe, pixel fields valid.
- pixel_x_in  in  ScreenX  column.
- pixel_y_in  in  ScreenY  row.
- pixel_value_in  in  16  RGB565 colour.
- render_busy  in  1  controller busy; a falling edge marks frame complete.
- vblank  in  1  display vertical blank (level).
- fb_ready  in  1  BRAM write port granted this cycle.
- fb_we  out  1  write enable.
- fb_addr  out  ADDR_WIDTH  write address.
- fb_data  out  16  write data.
- front_buf  out  1  buffer the display reads.
- frame_swapped  out  1  one-cycle pulse on swap.
- overflow  out  1  sticky: pixel dropped on a full FIFO.

Behaviour:
- Reset values: fb_we=0, fb_addr=0, fb_data=0, front_buf=0, back_buf=1, frame_swapped=0, overflow=0. FIFO empty; state=RENDER.
- Address stage, registered, 1 cycle:
  - lin = y*SCREEN_WIDTH + x, computed at full ADDR_WIDTH precision.
  - addr = lin + (back_buf ? SCREEN_WIDTH*SCREEN_HEIGHT : 0).
  - {addr, data} is pushed into the FIFO the cycle after the strobe.
- Out-of-range pixels (x >= SCREEN_WIDTH or y >= SCREEN_HEIGHT) are discarded silently. They do not set overflow.
- Push into a full FIFO: the entry is dropped and overflow is set. overflow clears only on rst. No backpressure reaches the controller.
- Drain side:
  - When FIFO is non-empty and fb_ready=1: fb_we=1, fb_addr/fb_data = head, pop in the same cycle.
  - Otherwise fb_we=0.
  - Minimum latency from strobe to fb_we is 2 cycles.
  - Simultaneous push and pop on a full FIFO: the pop frees the slot, the push is accepted, no overflow.
- FSM:
  - RENDER: a falling edge of render_busy (registered previous value) -> DRAIN.
  - DRAIN: FIFO empty and address stage idle -> WAIT_VBLANK.
  - WAIT_VBLANK: vblank=1 -> SWAP.
  - SWAP, 1 cycle: toggle front_buf and back_buf, pulse frame_swapped -> RENDER (or CLEAR, see Optional Feature).
- Pixels arriving in DRAIN/WAIT_VBLANK/SWAP are still written, using the back_buf value latched at the address stage.
- A rising edge of render_busy during DRAIN or WAIT_VBLANK aborts the pending swap: return to RENDER, buffers unchanged. This covers a new opFrame issued early.
- Reset mid-write drops all FIFO contents; fb_we is low on the cycle after rst.

Optional Feature:
- Macro: FRAMEBUFFER_CLEAR_ON_SWAP_EN.
- Defined:
  - After SWAP, enter CLEAR and write 16'h0000 to every address of the new back buffer, one address per fb_ready cycle.
  - Pixel writes have priority over clear writes; FIFO pops pre-empt clear.
  - CLEAR -> RENDER after the last address.
  - A render_busy falling edge during CLEAR is held pending and processed after CLEAR.
- Undefined: no CLEAR state; SWAP goes directly to RENDER; the back buffer keeps stale data.

Decomposition:
- proctypes package gains:
  - FB_ADDR_WIDTH constant.
  - FB_PIXELS = SCREEN_WIDTH*SCREEN_HEIGHT.
  - FbWrite struct {addr, data}.
  - fbwr_state enum (RENDER, DRAIN, WAIT_VBLANK, SWAP, CLEAR).
- Existing ScreenX/ScreenY reused.
- One sub-module: pixel_fifo, a synchronous FIFO of FbWrite with full/empty flags and simultaneous push/pop support.

Test Plan:
- After reset, strobe (x=3, y=2, colour 16'hF800) with fb_ready=1 -> two cycles later fb_we=1, fb_addr=320*2+3+57600=58243, fb_data=16'hF800.
- fb_ready=0, 9 strobes with FIFO_DEPTH=8 -> overflow=1; then raise fb_ready -> exactly 8 writes drain in order.
- Strobe with x=320 -> no write, overflow stays 0.
- render_busy 1->0 with 3 pixels queued, vblank held low -> no swap; assert vblank after the FIFO drains -> frame_swapped pulse, front_buf=1; next pixel (0,0) writes address 0.
- render_busy falls then rises again before vblank -> no swap, front_buf unchanged.
- With FRAMEBUFFER_CLEAR_ON_SWAP_EN, complete a swap -> 57600 zero writes to addresses 0..57599, interleaved pixel writes landing correctly, then state returns to RENDER.
